// File: rtl/multicycle_main_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_main_control_pkg
// Shared definitions for the multi-cycle RISC-V main control FSM:
//   - RV32I opcode constants for the supported instruction groups
//   - alu_op encodings (also consumed by the downstream ALU-control stage)
//   - FSM state encoding (also visible on the state_o debug port)
//   - instruction class encoding latched in DECODE
// -----------------------------------------------------------------------------
package multicycle_main_control_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_LDST = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_R     = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_BR    = 3'd4,
        CLS_ILL   = 3'd5
    } class_e;

endpackage

// File: rtl/multicycle_main_control_opcode_classifier.sv
// -----------------------------------------------------------------------------
// multicycle_main_control_opcode_classifier
// Purely combinational opcode -> instruction class decode.
// Ports:
//   opcode_i   in  7  instr[6:0] from the instruction register
//   class_o    out 3  decoded class (R / LOAD / STORE / BR / ILL)
//   illegal_o  out 1  opcode is not one of the supported groups
// -----------------------------------------------------------------------------
module multicycle_main_control_opcode_classifier
    import multicycle_main_control_pkg::*;
(
    input  logic [6:0] opcode_i,
    output class_e     class_o,
    output logic       illegal_o
);

    always_comb begin
        class_o = CLS_ILL;
        unique case (opcode_i)
            OP_RTYPE:  class_o = CLS_R;
            OP_LOAD:   class_o = CLS_LOAD;
            OP_STORE:  class_o = CLS_STORE;
            OP_BRANCH: class_o = CLS_BR;
            default:   class_o = CLS_ILL;
        endcase
    end

    assign illegal_o = (class_o == CLS_ILL);

endmodule

// File: rtl/multicycle_main_control.sv
// -----------------------------------------------------------------------------
// multicycle_main_control
// Main control FSM of the multi-cycle RISC-V datapath. Sequences
// IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH for R-type, load,
// store and beq, and counts retired instructions.
//
// Optional build macro: ILLEGAL_TRAP_EN
//   undefined: an illegal opcode pulses `illegal` for the DECODE cycle and the
//              FSM carries on with the next fetch.
//   defined:   an illegal opcode parks the FSM in TRAP (illegal held high,
//              everything else low) until rst_n is asserted.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   opcode               instr[6:0], valid from DECODE onward
//   imem_ready           instruction memory data valid (sampled in FETCH only)
//   dmem_ready           data memory access done (sampled in MEM only)
//   imem_req, ir_write, pc_write, branch, alu_op, alu_src, dmem_read,
//   dmem_write, mem_to_reg, reg_write, illegal   datapath controls
//   state_o              current state encoding (debug)
//   retired              retired-instruction count, wraps mod 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_main_control
    import multicycle_main_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    class_e           class_q, class_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    class_e           dec_class;
    logic             dec_illegal;

    multicycle_main_control_opcode_classifier u_classifier (
        .opcode_i  (opcode),
        .class_o   (dec_class),
        .illegal_o (dec_illegal)
    );

    // Next-state logic; `retire` marks the transition that completes an
    // instruction so the counter can never step twice in one cycle.
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (imem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                class_d = dec_class;
                if (dec_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    state_d = ST_FETCH;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_R:               state_d = ST_WB;
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_BR: begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                    default:             state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    if (class_q == CLS_STORE) begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:  state_d = ST_TRAP;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            class_q   <= CLS_NONE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Output decode from the registered state and latched class. The only
    // input-qualified terms are the FETCH handshake pulses and the DECODE
    // illegal flag, since the class is not latched until the end of DECODE.
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        alu_op     = ALUOP_LDST;
        alu_src    = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            ST_DECODE: illegal = dec_illegal;
            ST_EXEC: begin
                case (class_q)
                    CLS_R:               alu_op = ALUOP_R;
                    CLS_LOAD, CLS_STORE: alu_src = 1'b1;
                    CLS_BR: begin
                        alu_op = ALUOP_BR;
                        branch = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                // Address operands held so the ALU result stays stable.
                alu_src    = 1'b1;
                dmem_read  = (class_q == CLS_LOAD);
                dmem_write = (class_q == CLS_STORE);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (class_q == CLS_LOAD);
                if (class_q == CLS_R) alu_op = ALUOP_R;
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:  illegal = 1'b1;
`endif
            default: ;
        endcase
    end

    assign state_o = state_q;
    assign retired = retired_q;

endmodule
